block_serial_adder_subtractor: RTL and testbench
================================================

BLOCK_SERIAL_ADDER_SUBTRACTOR -- requirements
Module: block_serial_adder_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4, bits resolved per cycle (one lookahead block).
REQ-003 SHALL require WIDTH to be an integer multiple of BLOCK_SIZE; NBLK = WIDTH/BLOCK_SIZE.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request a new operation.
REQ-008 SHALL have port A, input, WIDTH, first operand.
REQ-009 SHALL have port B, input, WIDTH, second operand.
REQ-010 SHALL have port sub, input, 1, 0 = A+B, 1 = A-B.
REQ-011 SHALL have port busy, output, 1, operation in progress.
REQ-012 SHALL have port done, output, 1, one-cycle result-valid strobe.
REQ-013 SHALL have port S, output, WIDTH, sum/difference.
REQ-014 SHALL have port Cout, output, 1, carry out of the MSB (1 = no borrow when sub=1).
REQ-015 SHALL have port OF, output, 1, two's-complement overflow.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE with start=1 at a clock edge, latch A, B XOR {WIDTH{sub}}, and a carry register = sub, clear block index to 0, and enter RUN.
REQ-018 SHALL ignore start in RUN and DONE; latched operands SHALL NOT change mid-operation.
REQ-019 SHALL, each RUN cycle for block k: P = A_k XOR B'_k, G = A_k AND B'_k, internal carries by full lookahead from the carry register, S slice k = P XOR internal carries, carry register = block carry-out.
REQ-020 SHALL compute the block carry-out as OR over j of (G_j AND P_{j+1..BLOCK_SIZE-1}) OR (carry-in AND all P), not as a ripple chain.
REQ-021 SHALL increment the block index each RUN cycle and enter DONE on the edge that processes block NBLK-1.
REQ-022 SHALL, on that final edge, register Cout = MSB block carry-out and OF = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-023 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-024 SHALL, with start sampled at edge N, assert done in the cycle following edge N+NBLK (NBLK+1 cycles start-to-done inclusive).
REQ-025 SHALL drive busy=1 in RUN and DONE, 0 in IDLE.
REQ-026 SHALL hold S, Cout, OF stable from DONE until the next accepted start; S slices MAY update progressively during RUN.
REQ-027 SHALL accept a start asserted in the IDLE cycle immediately after DONE (back-to-back throughput one result per NBLK+2 cycles).
REQ-028 SHALL support NBLK=1 (WIDTH=BLOCK_SIZE): one RUN cycle, then DONE.

Reset
REQ-029 SHALL, on rst=1, immediately force state IDLE, busy=0, done=0, S=0, Cout=0, OF=0, block index 0, carry register 0.
REQ-030 SHALL abort any in-progress operation on reset without producing done; after release, the first start SHALL behave as from power-up.
REQ-031 SHALL ignore start while rst=1.

Verification (WIDTH=16, BLOCK_SIZE=4)
REQ-032 SHALL cover A=0x7FFF, B=0x0001, sub=0 -> done 5 cycles after start edge inclusive, S=0x8000, Cout=0, OF=1.
REQ-033 SHALL cover A=0xFFFF, B=0x0001, sub=0 -> S=0x0000, Cout=1, OF=0.
REQ-034 SHALL cover A=0x0000, B=0x0001, sub=1 -> S=0xFFFF, Cout=0, OF=0; and A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, Cout=1, OF=1.
REQ-035 SHALL cover start re-asserted with different operands during RUN -> ignored, result matches first operands, single done pulse.
REQ-036 SHALL cover rst asserted in second RUN cycle -> all outputs 0 immediately, no done; subsequent A=0x1234+B=0x1111 -> S=0x2345, Cout=0, OF=0.
REQ-037 SHALL cover back-to-back starts and random operands against a reference model of A±B, checking S, Cout, OF and done timing.

Source files
------------

// File: rtl/block_serial_adder_subtractor.sv
// Block-serial adder/subtractor: resolves BLOCK_SIZE bits per cycle with a
// full carry-lookahead block, carrying between blocks in a single register.
module block_serial_adder_subtractor #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OF
);

  localparam int NBLK  = WIDTH / BLOCK_SIZE;
  localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  if (WIDTH % BLOCK_SIZE != 0) begin : g_width_check
    $error("WIDTH must be a multiple of BLOCK_SIZE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        a_reg, b_reg;
  logic                    carry;
  logic [IDX_W-1:0]        idx;
  logic                    last_blk;
  logic [BLOCK_SIZE-1:0]   a_blk, b_blk, p, g, sum_blk;
  logic [BLOCK_SIZE:0]     c;

  // c[i] is the carry into bit i of the block; c[BLOCK_SIZE] is the block carry-out.
  // Every carry is a flat sum of products of G/P terms and the carry-in.
  function automatic logic [BLOCK_SIZE:0] lookahead(input logic [BLOCK_SIZE-1:0] pv,
                                                    input logic [BLOCK_SIZE-1:0] gv,
                                                    input logic              cin);
    logic [BLOCK_SIZE:0] cv;
    logic                term;
    cv    = '0;
    cv[0] = cin;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) term = term & pv[k];
      cv[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gv[j];
        for (int k = j + 1; k <= i; k++) term = term & pv[k];
        cv[i+1] = cv[i+1] | term;
      end
    end
    return cv;
  endfunction

  always_comb begin
    a_blk   = a_reg[int'(idx)*BLOCK_SIZE +: BLOCK_SIZE];
    b_blk   = b_reg[int'(idx)*BLOCK_SIZE +: BLOCK_SIZE];
    p       = a_blk ^ b_blk;
    g       = a_blk & b_blk;
    c       = lookahead(p, g, carry);
    sum_blk = p ^ c[BLOCK_SIZE-1:0];
  end

  assign last_blk = (idx == IDX_W'(NBLK - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_blk) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      OF    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          // Subtraction is A + ~B + 1: invert B once here, seed carry with sub.
          a_reg <= A;
          b_reg <= B ^ {WIDTH{sub}};
          carry <= sub;
          idx   <= '0;
        end
        RUN: begin
          S[int'(idx)*BLOCK_SIZE +: BLOCK_SIZE] <= sum_blk;
          carry <= c[BLOCK_SIZE];
          idx   <= last_blk ? '0 : idx + 1'b1;
          if (last_blk) begin
            Cout <= c[BLOCK_SIZE];
            OF   <= c[BLOCK_SIZE-1] ^ c[BLOCK_SIZE];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_serial_adder_subtractor.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// random back-to-back operations against an arithmetic A+/-B reference.
module tb_block_serial_adder_subtractor;

  localparam int WIDTH = 16;
  localparam int BS    = 4;
  localparam int NBLK  = WIDTH / BS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             sub;
  logic             busy, done;
  logic [WIDTH-1:0] s;
  logic             cout, of;

  int n_vec = 0;
  int n_err = 0;

  block_serial_adder_subtractor #(.WIDTH(WIDTH), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .sub(sub),
    .busy(busy), .done(done), .S(s), .Cout(cout), .OF(of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vsub;
    logic [WIDTH-1:0] es;
    logic             ec;
    logic             eo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the true operand values.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic msub,
                       output logic [WIDTH-1:0] es, output logic ec, output logic eo);
    int sa, sb, sres;
    logic [WIDTH:0] full;
    sa = $signed(ma);
    sb = $signed(mb);
    if (msub) begin
      full = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
      sres = sa - sb;
    end else begin
      full = {1'b0, ma} + {1'b0, mb};
      sres = sa + sb;
    end
    es = full[WIDTH-1:0];
    ec = full[WIDTH];
    eo = (sres > 32767) || (sres < -32768);
  endtask

  // Caller is at a negedge with the DUT idle (or in the IDLE cycle right after DONE).
  task automatic run_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vsub, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int cyc;
    a = va; b = vb; sub = vsub; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, NBLK);
    check({name, " S"}, s, es);
    check({name, " Cout"}, cout, ec);
    check({name, " OF"}, of, eo);
    @(negedge clk);
    check({name, " done pulse"}, {busy, done}, 2'b00);
    check({name, " S hold"}, s, es);
  endtask

  vec_t vecs[8];
  logic [WIDTH-1:0] es, ra, rb, s_at_done;
  logic             ec, eo, rsub;
  int               ndone, cyc_done;

  initial begin
    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    #1;
    check("reset outputs", {busy, done, cout, of, s}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
             vecs[i].es, vecs[i].ec, vecs[i].eo);

    // start held high through RUN with different operands must be ignored
    a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    ndone = 0; cyc_done = 0; s_at_done = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) start = 1'b0;
      if (done) begin
        ndone++;
        cyc_done  = c;
        s_at_done = s;
      end
    end
    check("start in RUN single done", ndone, 1);
    check("start in RUN latency", cyc_done, NBLK);
    check("start in RUN S", s_at_done, 16'h2345);

    // reset in the second RUN cycle aborts with no done
    a = 16'h7777; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async reset outputs", {busy, done, cout, of, s}, '0);
    start = 1'b1;
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    if (done || busy) ndone++;
    check("no activity around reset", ndone, 0);
    run_op("post-reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // random operands, issued back-to-back in the IDLE cycle after each DONE
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rsub = $urandom_range(0, 1);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rsub, es, ec, eo);
      run_op($sformatf("rand%0d", i), ra, rb, rsub, es, ec, eo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
